nios2_debug_ocimem: RTL and testbench

Debug-side on-chip memory for the Nios II debug slave, directly downstream of the system-clock debug slave stage. It consumes the synchronized `jdo` word and the `take_action_ocimem_*` / `take_no_action_ocimem_a` pulses, and performs JTAG reads and writes into a 256x32 debug RAM. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug slave wrapper. A CPU-side Avalon-MM slave shares the same RAM, and JTAG accesses have priority over CPU accesses.

---
 rtl/nios2_debug_ocimem.sv | 178 +++++++++++++++++
 tb/tb_nios2_debug_ocimem.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_debug_ocimem.sv
// Debug on-chip RAM (2^ADDR_W x 32) shared by JTAG debug pulses and a CPU Avalon-MM slave.
// Ports: jdo/take_* (JTAG side), address/read/write/... (CPU side), MonDReg/monitor_* (to wrapper).
module nios2_debug_ocimem #(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] PROT_BASE = 8'hE0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_JRD, S_JCAP, S_JWR, S_CRD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic [3:0]        ram_be;

  logic              jtag_pulse;
  logic              idle;
  logic              grant;
  logic              prot_hit;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign jtag_pulse = take_action_ocimem_a
                    | take_no_action_ocimem_a
                    | take_action_ocimem_b;
  assign idle       = (state_q == S_IDLE);
  assign grant      = idle & ~jtag_pulse;
  assign prot_hit   = (address >= PROT_BASE) & ~debugaccess;

  // A granted read stalls for its address cycle and completes in CRD.
  always_comb begin
    if (state_q == S_CRD) begin
      waitrequest = 1'b0;
    end else begin
      waitrequest = ((read | write) & ~grant)
                  | (grant & read & ~write);
    end
  end

  // In CRD the RAM output is forwarded so data is valid with waitrequest low.
  assign readdata = (state_q == S_CRD) ? ram_q : rdata_q;

  assign MonDReg       = mon_d_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;

  always_comb begin
    state_d   = state_q;
    mon_a_d   = mon_a_q;
    mon_d_d   = mon_d_q;
    rdy_d     = rdy_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ram_addr  = address;
    ram_wdata = writedata;
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    unique case (state_q)
      S_IDLE: begin
        if (take_action_ocimem_a) begin
          mon_a_d = jdo[ADDR_W+25:26];
          rdy_d   = 1'b0;
          if (jdo[34]) err_d = 1'b0;
          if (jdo[35]) state_d = S_JRD;
        end else if (take_no_action_ocimem_a) begin
          rdy_d   = 1'b0;
          state_d = S_JRD;
        end else if (take_action_ocimem_b) begin
          rdy_d   = 1'b0;
          wdata_d = jdo[34:3];
          state_d = S_JWR;
        end else if (write) begin
          // Protected writes are acknowledged but leave the RAM untouched.
          ram_we = ~prot_hit;
          ram_be = prot_hit ? 4'h0 : byteenable;
        end else if (read) begin
          state_d = S_CRD;
        end
      end
      S_JRD: begin
        ram_addr = mon_a_q;
        state_d  = S_JCAP;
      end
      S_JCAP: begin
        mon_d_d = ram_q;
        rdy_d   = 1'b1;
        mon_a_d = mon_a_q + 1'b1;
        state_d = S_IDLE;
      end
      S_JWR: begin
        ram_addr  = mon_a_q;
        ram_wdata = wdata_q;
        ram_we    = 1'b1;
        ram_be    = 4'hF;
        rdy_d     = 1'b1;
        mon_a_d   = mon_a_q + 1'b1;
        state_d   = S_IDLE;
      end
      S_CRD: begin
        rdata_d = ram_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Overrun: drop the pulse, flag it; a clear request still wins.
    if (!idle && jtag_pulse) begin
      err_d = 1'b1;
      if (take_action_ocimem_a && jdo[34]) begin
        err_d = 1'b0;
        rdy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mon_a_q <= '0;
      mon_d_q <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    ram_q <= mem[ram_addr];
  end

endmodule

// File: tb/tb_nios2_debug_ocimem.sv
// Self-checking bench for nios2_debug_ocimem.
// Directed JTAG/CPU scenarios plus randomized traffic against an array model.
module tb_nios2_debug_ocimem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta_a, ta_na, ta_b;
  logic [7:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        debugaccess;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int tests = 0;
  int fails = 0;

  logic [31:0] ref_mem [256];
  bit          valid   [256];
  logic [7:0]  ref_a;
  logic        ref_err;
  logic [31:0] ref_mond;

  nios2_debug_ocimem dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_no_action_ocimem_a (ta_na),
    .take_action_ocimem_b    (ta_b),
    .address                 (address),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .debugaccess             (debugaccess),
    .readdata                (readdata),
    .waitrequest             (waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [37:0] mk_a(logic [7:0] a, bit clr, bit rd);
    logic [37:0] v;
    v        = '0;
    v[35]    = rd;
    v[34]    = clr;
    v[33:26] = a;
    return v;
  endfunction

  function automatic logic [37:0] mk_b(logic [31:0] d);
    logic [37:0] v;
    v       = '0;
    v[34:3] = d;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic jtag_wr(logic [7:0] a, logic [31:0] d);
    jdo  = mk_a(a, 1'b1, 1'b0);
    ta_a = 1'b1;
    tick();
    ta_a = 1'b0;
    jdo  = mk_b(d);
    ta_b = 1'b1;
    tick();
    ta_b = 1'b0;
    chk("jwr_busy", {31'd0, monitor_ready}, 32'd0);
    tick();
    chk("jwr_ready", {31'd0, monitor_ready}, 32'd1);
    ref_mem[a] = d;
    valid[a]   = 1'b1;
    ref_a      = a + 8'd1;
    ref_err    = 1'b0;
  endtask

  task automatic jtag_rd(bit use_na, logic [7:0] a);
    if (use_na) begin
      ta_na = 1'b1;
    end else begin
      jdo     = mk_a(a, 1'b1, 1'b1);
      ta_a    = 1'b1;
      ref_a   = a;
      ref_err = 1'b0;
    end
    tick();
    ta_a  = 1'b0;
    ta_na = 1'b0;
    chk("jrd_busy", {31'd0, monitor_ready}, 32'd0);
    tick();
    tick();
    ref_mond = ref_mem[ref_a];
    chk("jrd_data", MonDReg, ref_mond);
    chk("jrd_ready", {31'd0, monitor_ready}, 32'd1);
    chk("jrd_err", {31'd0, monitor_error}, {31'd0, ref_err});
    ref_a = ref_a + 8'd1;
  endtask

  task automatic cpu_wr(logic [7:0] a, logic [31:0] d,
                        logic [3:0] be, bit dbg);
    address     = a;
    writedata   = d;
    byteenable  = be;
    debugaccess = dbg;
    write       = 1'b1;
    #1;
    chk("cwr_wait", {31'd0, waitrequest}, 32'd0);
    tick();
    write = 1'b0;
    if (a < 8'hE0 || dbg) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic cpu_rd(logic [7:0] a);
    address = a;
    read    = 1'b1;
    #1;
    chk("crd_wait1", {31'd0, waitrequest}, 32'd1);
    tick();
    chk("crd_wait0", {31'd0, waitrequest}, 32'd0);
    chk("crd_data", readdata, ref_mem[a]);
    tick();
    read = 1'b0;
  endtask

  initial begin
    logic [7:0]  ra;
    logic [31:0] rd32;
    logic [31:0] exp_wait;
    reset_n     = 1'b0;
    jdo         = '0;
    ta_a        = 1'b0;
    ta_na       = 1'b0;
    ta_b        = 1'b0;
    address     = '0;
    read        = 1'b0;
    write       = 1'b0;
    writedata   = '0;
    byteenable  = '0;
    debugaccess = 1'b0;
    ref_a       = '0;
    ref_err     = 1'b0;
    ref_mond    = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      valid[i]   = 1'b0;
    end
    tick();
    tick();
    chk("rst_mondreg", MonDReg, 32'd0);
    chk("rst_ready", {31'd0, monitor_ready}, 32'd0);
    chk("rst_error", {31'd0, monitor_error}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_wait", {31'd0, waitrequest}, 32'd0);
    reset_n = 1'b1;
    tick();

    // JTAG write then read, MonAReg auto-increment
    jtag_wr(8'h11, 32'h1111_1111);
    jtag_wr(8'h10, 32'hDEAD_BEEF);
    jtag_rd(1'b0, 8'h10);
    jtag_rd(1'b1, 8'h00);

    // Streamed reads wrapping past 0xFF
    jtag_wr(8'hFE, 32'h0000_000A);
    jtag_wr(8'hFF, 32'h0000_000B);
    jtag_wr(8'h00, 32'h0000_000C);
    jtag_wr(8'h01, 32'h0000_000D);
    jtag_rd(1'b0, 8'hFE);
    tick();
    jtag_rd(1'b1, 8'h00);
    tick();
    jtag_rd(1'b1, 8'h00);
    tick();
    jtag_rd(1'b1, 8'h00);

    // JTAG read collides with CPU read of 0x20
    jtag_wr(8'h20, 32'h2020_5A5A);
    address = 8'h20;
    read    = 1'b1;
    jdo     = mk_a(8'h10, 1'b1, 1'b1);
    ta_a    = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      exp_wait = (c <= 4) ? 32'd1 : 32'd0;
      chk("coll_wait", {31'd0, waitrequest}, exp_wait);
      if (c == 4) chk("coll_jtag", MonDReg, ref_mem[8'h10]);
      if (c == 5) chk("coll_cpu", readdata, ref_mem[8'h20]);
      tick();
      ta_a = 1'b0;
    end
    read     = 1'b0;
    ref_a    = 8'h11;
    ref_mond = ref_mem[8'h10];

    // Protected region
    jtag_wr(8'hE4, 32'hCAFE_F00D);
    cpu_wr(8'hE4, 32'h1234_5678, 4'hF, 1'b0);
    cpu_rd(8'hE4);
    cpu_wr(8'hE4, 32'h1234_5678, 4'b0011, 1'b1);
    cpu_rd(8'hE4);
    chk("prot_merge", ref_mem[8'hE4], 32'hCAFE_5678);
    cpu_wr(8'hDF, 32'h0BAD_F00D, 4'hF, 1'b0);
    cpu_rd(8'hDF);

    // Overrun: second pulse during JWR is dropped
    jdo  = mk_a(8'h40, 1'b1, 1'b0);
    ta_a = 1'b1;
    tick();
    ta_a = 1'b0;
    jdo  = mk_b(32'h1357_2468);
    ta_b = 1'b1;
    tick();
    ta_b  = 1'b0;
    ta_na = 1'b1;
    tick();
    ta_na = 1'b0;
    ref_mem[8'h40] = 32'h1357_2468;
    valid[8'h40]   = 1'b1;
    chk("ovr_error", {31'd0, monitor_error}, 32'd1);
    chk("ovr_ready", {31'd0, monitor_ready}, 32'd1);
    tick();
    tick();
    chk("ovr_dropped", MonDReg, ref_mond);
    jdo  = mk_a(8'h40, 1'b1, 1'b0);
    ta_a = 1'b1;
    tick();
    ta_a = 1'b0;
    chk("clr_error", {31'd0, monitor_error}, 32'd0);
    chk("clr_ready", {31'd0, monitor_ready}, 32'd0);
    jtag_rd(1'b0, 8'h40);

    // Overrun during a CPU read in CRD
    address = 8'h10;
    read    = 1'b1;
    tick();
    ta_b = 1'b1;
    jdo  = mk_b(32'hFFFF_FFFF);
    #1;
    chk("crd_ovr_data", readdata, ref_mem[8'h10]);
    tick();
    ta_b = 1'b0;
    read = 1'b0;
    chk("crd_ovr_err", {31'd0, monitor_error}, 32'd1);
    ref_err = 1'b1;
    jtag_rd(1'b1, 8'h00);

    // Reset during JRD
    jdo  = mk_a(8'h20, 1'b1, 1'b1);
    ta_a = 1'b1;
    tick();
    ta_a    = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rjrd_mond", MonDReg, 32'd0);
    chk("rjrd_ready", {31'd0, monitor_ready}, 32'd0);
    chk("rjrd_error", {31'd0, monitor_error}, 32'd0);
    chk("rjrd_rdata", readdata, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    ref_a   = 8'h00;
    ref_err = 1'b0;

    // Reset during JWR: the write must not land
    jdo  = mk_a(8'h20, 1'b1, 1'b0);
    ta_a = 1'b1;
    tick();
    ta_a = 1'b0;
    jdo  = mk_b(32'hFFFF_0000);
    ta_b = 1'b1;
    tick();
    ta_b    = 1'b0;
    reset_n = 1'b0;
    #1;
    tick();
    reset_n = 1'b1;
    tick();
    ref_a = 8'h00;
    cpu_rd(8'h20);
    jtag_rd(1'b1, 8'h00);

    // Randomized mixed traffic around the protection boundary
    for (int i = 0; i < 24; i++)
      jtag_wr(8'hD8 + 8'(i), $urandom);
    for (int i = 0; i < 60; i++) begin
      ra   = 8'hD8 + 8'($urandom_range(0, 23));
      rd32 = $urandom;
      case ($urandom_range(0, 4))
        0: jtag_wr(ra, rd32);
        1: jtag_rd(1'b0, ra);
        2: cpu_wr(ra, rd32, 4'($urandom), 1'($urandom));
        3: cpu_rd(ra);
        default: begin
          if (valid[ref_a]) jtag_rd(1'b1, 8'h00);
          else cpu_rd(ra);
        end
      endcase
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
